// File: rtl/apu_dac_mc.sv
// Multi-channel audio DAC output stage: per-channel PWM or first-order sigma-delta
// modulation of double-buffered N-bit samples, with samples swapped only at period wraps.

module apu_dac_lane #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         step,
    input  logic         wrap,
    input  logic         load,
    input  logic         pending,
    input  logic         mode_r,
    input  logic         acc_clr,
    input  logic [N-1:0] cnt,
    input  logic [N-1:0] sample,
    output logic         q
);
    logic [N-1:0] shadow;
    logic [N-1:0] active;
    logic [N-1:0] acc;
    logic [N:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, active};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow <= '0;
            active <= '0;
            acc    <= '0;
            q      <= 1'b0;
        end else begin
            if (load)
                shadow <= sample;
            // a load coinciding with the wrap bypasses the shadow register
            if (wrap) begin
                if (load)
                    active <= sample;
                else if (pending)
                    active <= shadow;
            end
            if (!en)
                q <= 1'b0;
            else if (step)
                q <= mode_r ? sum[N] : (cnt < active);
            if (acc_clr)
                acc <= '0;
            else if (step && mode_r)
                acc <= sum[N-1:0];
        end
    end
endmodule

module apu_dac_mc #(
    parameter int N   = 8,
    parameter int CH  = 2,
    parameter int DIV = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            mode,
    input  logic [CH*N-1:0] cmp,
    input  logic            load,
    output logic [CH-1:0]   q,
    output logic            frame,
    output logic            ovf
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DW-1:0]        div_cnt;
    logic [N-1:0]         cnt;
    logic                 pending;
    logic                 mode_r;
    logic                 tick;
    logic                 step;
    logic                 wrap;
    logic                 acc_clr;
    logic [CH-1:0][N-1:0] sample;

    assign sample  = cmp;
    assign tick    = (div_cnt == DW'(DIV - 1));
    assign step    = tick & en;
    assign wrap    = step & (cnt == '1);
    assign acc_clr = wrap & (mode != mode_r);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            cnt     <= '0;
            pending <= 1'b0;
            mode_r  <= 1'b0;
            frame   <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (en)
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (step)
                cnt <= cnt + 1'b1;
            if (wrap) begin
                pending <= 1'b0;
                mode_r  <= mode;
            end else if (load) begin
                pending <= 1'b1;
            end
            frame <= wrap;
            ovf   <= load & pending & ~wrap;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_lane
        apu_dac_lane #(.N(N)) u_lane (
            .clk     (clk),
            .reset   (reset),
            .en      (en),
            .step    (step),
            .wrap    (wrap),
            .load    (load),
            .pending (pending),
            .mode_r  (mode_r),
            .acc_clr (acc_clr),
            .cnt     (cnt),
            .sample  (sample[c]),
            .q       (q[c])
        );
    end
endmodule

// File: tb/tb_apu_dac_mc.sv
// Scoreboard bench for apu_dac_mc: two instances (DIV=1 and DIV=4) share one randomized
// stimulus stream and are checked every cycle against an arithmetic reference model.

module tb_apu_dac_mc;
    localparam int N  = 8;
    localparam int CH = 2;
    localparam int M  = 1 << N;

    typedef struct packed {
        logic [CH-1:0] q;
        logic          frame;
        logic          ovf;
    } obs_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            en = 1'b0;
    logic            mode = 1'b0;
    logic            load = 1'b0;
    logic [CH*N-1:0] cmp = '0;
    logic [CH-1:0]   q0, q1;
    logic            frame0, frame1, ovf0, ovf1;

    int checks = 0;
    int passes = 0;

    // reference model state, index 0 -> DIV=1, index 1 -> DIV=4
    int            en_cyc [2];
    int            shadow [2][CH];
    int            active [2][CH];
    int            acc    [2][CH];
    bit            pending[2];
    bit            mode_r [2];
    logic [CH-1:0] q_m    [2];
    obs_t          sbq0[$];
    obs_t          sbq1[$];

    always #5 clk = ~clk;

    apu_dac_mc #(.N(N), .CH(CH), .DIV(1)) dut0 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .cmp(cmp), .load(load),
        .q(q0), .frame(frame0), .ovf(ovf0)
    );

    apu_dac_mc #(.N(N), .CH(CH), .DIV(4)) dut1 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .cmp(cmp), .load(load),
        .q(q1), .frame(frame1), .ovf(ovf1)
    );

    // Tick timing is derived from the number of enabled cycles: tick k (0-based) lands
    // on enabled cycle k*DIV+DIV-1 and sits at period position k mod 2^N.
    task automatic model_step(input int g, output obs_t o);
        int d;
        int pos;
        int v;
        bit tick;
        bit wrap;
        d = (g == 0) ? 1 : 4;
        o = '0;
        if (reset) begin
            en_cyc[g]  = 0;
            pending[g] = 0;
            mode_r[g]  = 0;
            q_m[g]     = '0;
            for (int c = 0; c < CH; c++) begin
                shadow[g][c] = 0;
                active[g][c] = 0;
                acc[g][c]    = 0;
            end
            return;
        end
        tick = en && ((en_cyc[g] % d) == d - 1);
        pos  = (en_cyc[g] / d) % M;
        wrap = tick && (pos == M - 1);
        o.frame = wrap;
        o.ovf   = load && pending[g] && !wrap;
        if (!en) q_m[g] = '0;
        for (int c = 0; c < CH; c++) begin
            v = int'(cmp[c*N +: N]);
            if (tick) begin
                if (mode_r[g]) begin
                    q_m[g][c]  = (acc[g][c] + active[g][c]) >= M;
                    acc[g][c]  = (acc[g][c] + active[g][c]) % M;
                end else begin
                    q_m[g][c]  = pos < active[g][c];
                end
            end
            if (wrap) begin
                if (load) active[g][c] = v;
                else if (pending[g]) active[g][c] = shadow[g][c];
                if (mode != mode_r[g]) acc[g][c] = 0;
            end
            if (load) shadow[g][c] = v;
        end
        if (wrap) begin
            pending[g] = 0;
            mode_r[g]  = mode;
        end else if (load) begin
            pending[g] = 1;
        end
        if (en) en_cyc[g]++;
        o.q = q_m[g];
    endtask

    always @(posedge clk) begin : model
        obs_t o;
        model_step(0, o);
        sbq0.push_back(o);
        model_step(1, o);
        sbq1.push_back(o);
    end

    task automatic cmp_obs(input string nm, input obs_t e, input obs_t a);
        checks++;
        if (a === e) passes++;
        else $display("FAIL %s t=%0t got q=%b frame=%b ovf=%b want q=%b frame=%b ovf=%b",
                      nm, $time, a.q, a.frame, a.ovf, e.q, e.frame, e.ovf);
    endtask

    always @(posedge clk) begin : monitor
        obs_t a;
        #2;
        a = '{q: q0, frame: frame0, ovf: ovf0};
        if (sbq0.size() == 0) begin
            checks++;
            $display("FAIL div1_sb_empty t=%0t", $time);
        end else cmp_obs("div1", sbq0.pop_front(), a);
        a = '{q: q1, frame: frame1, ovf: ovf1};
        if (sbq1.size() == 0) begin
            checks++;
            $display("FAIL div4_sb_empty t=%0t", $time);
        end else cmp_obs("div4", sbq1.pop_front(), a);
    end

    task automatic do_load(input logic [N-1:0] v1, input logic [N-1:0] v0);
        @(negedge clk);
        cmp  = {v1, v0};
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [N-1:0] pick_sample();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return N'(M / 2);
            3: return N'(M / 4);
            default: return N'($urandom_range(0, M - 1));
        endcase
    endfunction

    initial begin : stim
        int en_hold;
        bit found;
        // reset held with arbitrary inputs
        repeat (5) begin
            @(negedge clk);
            en   = 1'($urandom);
            mode = 1'($urandom);
            load = 1'($urandom);
            cmp  = CH*N'($urandom);
        end
        @(negedge clk);
        reset = 1'b0; en = 1'b1; mode = 1'b0; load = 1'b0; cmp = '0;
        idle(600);

        // PWM duty, then back to zero
        do_load(8'd255, 8'd64);
        idle(2200);
        do_load(8'd0, 8'd0);
        idle(1100);

        // double buffering: overwrite before use
        do_load(8'd32, 8'd32);
        idle(40);
        do_load(8'd96, 8'd96);
        idle(1100);

        // load exactly on the DIV=1 wrap cycle
        found = 0;
        for (int i = 0; i < 600 && !found; i++) begin
            if ((en_cyc[0] % M) == M - 1) found = 1;
            else @(negedge clk);
        end
        checks++;
        if (found) passes++;
        else $display("FAIL wrap_align_timeout t=%0t", $time);
        cmp = {8'd200, 8'd17};
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        idle(600);

        // sigma-delta, 128 and 64
        mode = 1'b1;
        do_load(8'd64, 8'd128);
        idle(2200);
        // mode switch mid-period, then back
        mode = 1'b0;
        idle(1100);
        mode = 1'b1;
        idle(1100);

        // enable drop
        en = 1'b0;
        idle(10);
        en = 1'b1;
        idle(1100);

        // reset mid-operation with a pending sample
        mode = 1'b0;
        do_load(8'd250, 8'd250);
        idle(1100);
        do_load(8'd10, 8'd10);
        idle(30);
        reset = 1'b1;
        #1;
        checks++;
        if ({q0, q1} === '0) passes++;
        else $display("FAIL async_reset_q got q0=%b q1=%b want 0", q0, q1);
        idle(3);
        reset = 1'b0;
        idle(1100);

        // randomized traffic
        en_hold = 0;
        repeat (12000) begin
            @(negedge clk);
            load = ($urandom_range(0, 149) == 0);
            if (load) cmp = {pick_sample(), pick_sample()};
            if ($urandom_range(0, 2999) == 0) mode = ~mode;
            if (en_hold > 0) begin
                en_hold--;
                if (en_hold == 0) en = 1'b1;
            end else if ($urandom_range(0, 999) == 0) begin
                en = 1'b0;
                en_hold = $urandom_range(1, 20);
            end
            if ($urandom_range(0, 7999) == 0) reset = 1'b1;
            else reset = 1'b0;
        end
        @(negedge clk);
        reset = 1'b0; load = 1'b0; en = 1'b1;
        idle(4);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
